hamming_secded_decoder: RTL and testbench
=========================================

# hamming_secded_decoder

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) decoder. It is the successor to the team's fixed 15/11 parity checker and adds the following:
- generic codeword width;
- an extended overall-parity bit;
- single-bit correction;
- valid/ready flow control on both sides;
- saturating error statistics counters.

It sits on the receive path between the link deserialiser and the payload consumer.

## Interface
Parameters:
- `R`, default 4: number of Hamming parity bits, legal range 3..6. Derived values:
  - `CW_W = 2**R`, the codeword width.
  - `D_W = 2**R - 1 - R`, the data width (11 when `R=4`).
- `CNT_W`, default 16: width of each statistics counter.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the input codeword is valid.
- `in_ready` out 1: the decoder accepts the input this cycle.
- `in_code` in `CW_W`: codeword. Bit 0 is overall even parity; bits 1..`CW_W`-1 are Hamming positions; power-of-two positions are parity bits.
- `out_valid` out 1: the output word is valid.
- `out_ready` in 1: the downstream block accepts the output.
- `out_data` out `D_W`: decoded data.
- `out_single` out 1: a single-bit error was detected (and corrected when the correction macro is set).
- `out_double` out 1: an uncorrectable double error was detected.
- `cnt_clr` in 1: synchronous clear of both counters.
- `cnt_single` out `CNT_W`: count of single-error words.
- `cnt_double` out `CNT_W`: count of double-error words.

## Operation
Syndrome and overall parity are combinational on `in_code`:
- `s` is the XOR of the indices i (1..`CW_W`-1) for every position where `in_code[i]=1`; it is R bits wide.
- `p` is the XOR of all `CW_W` bits.

Classification:
- `s==0 && p==0`: clean.
- `s!=0 && p==1`: single error at position `s`; flip that bit before extraction.
- `s==0 && p==1`: single error in bit 0; the data is unaffected. Assert `out_single`.
- `s!=0 && p==0`: double error. Assert `out_double` and force `out_data` to 0.

Data extraction:
- Take the non-power-of-two positions in ascending order.
- `out_data[0]` is position 3, `out_data[1]` is position 5, `out_data[2]` is position 6, `out_data[3]` is position 7, and so on up to position `CW_W`-1.
- `out_single` and `out_double` are mutually exclusive.

Output register stage:
- The stage is a single entry holding `out_data`, `out_single` and `out_double`.
- `in_ready = !out_valid || out_ready`, purely combinational; no combinational path from `in_valid` to `in_ready`.
- An input handshake (`in_valid && in_ready`) loads the register and sets `out_valid` to 1.
- An output handshake with no new input clears `out_valid` to 0.
- While `out_valid && !out_ready`, the `out_*` signals are held stable.

Counters:
- A counter increments when a word with the matching flag is loaded into the output register, not when it is consumed.
- Counters saturate at all ones.
- If `cnt_clr` and an increment occur in the same cycle, the clear wins and the counter becomes 0.

## Timing
- Latency: a word accepted on cycle N is presented with `out_valid=1` on cycle N+1.
- Throughput: one word per cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `out_data=0`, `out_single=0`, `out_double=0`, `cnt_single=0`, `cnt_double=0`. `in_ready` is 1 in the cycle after reset.
- Reset has priority over every other input. A reset asserted while a word is held discards that word; counters do not count it.
- Simultaneous input and output handshakes in one cycle: the register reloads, `out_valid` stays 1, and there is no bubble.
- The counters reflect a loaded word on the same edge that raises `out_valid` for it.
- No state machine beyond the `out_valid` flag.

## Configuration
- `SECDED_CORRECT_EN` defined:
  - A single error at position `s` is corrected.
  - `out_single=1`.
  - `out_data` is the corrected payload.
- `SECDED_CORRECT_EN` undefined (detect-only):
  - A single error raises `out_single=1`.
  - `out_data` is extracted from the uncorrected codeword.
  - No correction logic is built.
- Double-error handling, the handshake and the counters are identical in both builds.

## Test plan
All scenarios use `R=4` with correction enabled unless stated.
- Clean word: `in_code=16'h000F` -> `out_data=11'h001`, `out_single=0`, `out_double=0`, one cycle later; no counter changes.
- Single error: `in_code=16'h0020` (zero word with bit 5 flipped) -> `out_data=11'h000`, `out_single=1`, `cnt_single=1`. In the detect-only build, `out_data=11'h002` and `out_single=1`.
- Parity-bit error: `in_code=16'h000E` -> `out_data=11'h001`, `out_single=1`.
- Double error: `in_code=16'h0003` -> `out_double=1`, `out_data=0`, `cnt_double` increments.
- Backpressure: stream 4 words with `out_ready` low for 3 cycles mid-stream -> `in_ready=0` while the output is held, outputs stay stable, no word is lost or duplicated, and the order is preserved.
- Saturation and clear, with `CNT_W=2`:
  - 5 single-error words -> `cnt_single=3`.
  - `cnt_clr` asserted in the same cycle as a single-error load -> `cnt_single=0`.
  - `rst` while `out_valid=1` -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// Pipelined Hamming SECDED decoder with valid/ready handshake and saturating error counters.
// Define SECDED_CORRECT_EN to build single-bit correction; otherwise the decoder only detects.
module hamming_secded_decoder #(
  parameter int R = 4,
  parameter int CNT_W = 16,
  localparam int CW_W = 2**R,
  localparam int D_W = 2**R - 1 - R
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_W-1:0]   out_data,
  output logic             out_single,
  output logic             out_double,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  function automatic logic [D_W-1:0] extract(input logic [CW_W-1:0] c);
    logic [D_W-1:0] res;
    int k;
    res = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        res[k] = c[i];
        k++;
      end
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [R-1:0]     syn_p0;
  logic             par_p0;
  logic             dbl_p0;
  logic [CW_W-1:0]  fixed_p0;
  logic [D_W-1:0]   data_p0;
  logic             load;

  logic             vld_p1_q, vld_p1_d;
  logic [D_W-1:0]   data_p1_q;
  logic             single_p1_q;
  logic             double_p1_q;
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

  // Stage p0: syndrome, overall parity, classification and extraction
  always_comb begin
    syn_p0 = '0;
    par_p0 = 1'b0;
    for (int i = 0; i < CW_W; i++) begin
      if (in_code[i]) begin
        par_p0 = ~par_p0;
        syn_p0 = syn_p0 ^ i[R-1:0];
      end
    end
  end

  assign dbl_p0 = (syn_p0 != '0) && !par_p0;

  always_comb begin
`ifdef SECDED_CORRECT_EN
    fixed_p0 = in_code;
    if (par_p0 && (syn_p0 != '0))
      fixed_p0 = in_code ^ (CW_W'(1) << syn_p0);
`else
    fixed_p0 = in_code;
`endif
    data_p0 = dbl_p0 ? '0 : extract(fixed_p0);
  end

  assign in_ready = !vld_p1_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (load)
      vld_p1_d = 1'b1;
    else if (out_ready)
      vld_p1_d = 1'b0;

    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    // Clear outranks a same-cycle increment
    if (cnt_clr) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (load) begin
      if (par_p0) cnt_single_d = sat_inc(cnt_single_q);
      if (dbl_p0) cnt_double_d = sat_inc(cnt_double_q);
    end
  end

  // Stage p1: single-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      data_p1_q    <= '0;
      single_p1_q  <= 1'b0;
      double_p1_q  <= 1'b0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
      if (load) begin
        data_p1_q   <= data_p0;
        single_p1_q <= par_p0;
        double_p1_q <= dbl_p0;
      end
    end
  end

  assign out_valid  = vld_p1_q;
  assign out_data   = data_p1_q;
  assign out_single = single_p1_q;
  assign out_double = double_p1_q;
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder (R=4, CNT_W=2); follows SECDED_CORRECT_EN if defined.
module tb_hamming_secded_decoder;
  localparam int R = 4;
  localparam int CNT_W = 2;
  localparam int CW = 16;
  localparam int DW = 11;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          dbl;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_code;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_single;
  logic             out_double;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;

  hamming_secded_decoder #(.R(R), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_single(out_single), .out_double(out_double),
    .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  logic m_vld;
  logic [CNT_W-1:0] m_cs, m_cd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] m_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int k;
    logic p;
    c = '0;
    k = 0;
    for (int i = 1; i < CW; i++)
      if ($countones(i) != 1) begin
        c[i] = d[k];
        k++;
      end
    for (int j = 0; j < R; j++) begin
      p = 1'b0;
      for (int i = 3; i < CW; i++)
        if ($countones(i) != 1 && i[j]) p = p ^ c[i];
      c[1 << j] = p;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DW-1:0] unpack_data(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < CW; i++)
      if ($countones(i) != 1) begin
        d[k] = c[i];
        k++;
      end
    return d;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input logic v, input logic [CW-1:0] code, input exp_t e,
                       input logic ordy, input logic clr, output logic acc);
    exp_t f;
    logic pop;
    in_valid = v;
    in_code = code;
    out_ready = ordy;
    cnt_clr = clr;
    @(negedge clk);
    chk("in_ready", in_ready, !m_vld || ordy);
    chk("out_valid", out_valid, m_vld);
    if (m_vld) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        f = sb[0];
        chk("out_data", out_data, f.d);
        chk("out_single", out_single, f.s);
        chk("out_double", out_double, f.dbl);
      end
    end
    chk("cnt_single", cnt_single, m_cs);
    chk("cnt_double", cnt_double, m_cd);
    pop = m_vld && ordy;
    acc = v && (!m_vld || ordy);
    if (pop && sb.size() > 0) void'(sb.pop_front());
    if (acc) sb.push_back(e);
    m_vld = acc ? 1'b1 : (pop ? 1'b0 : m_vld);
    if (clr) begin
      m_cs = '0;
      m_cd = '0;
    end else if (acc) begin
      if (e.s) m_cs = m_inc(m_cs);
      if (e.dbl) m_cd = m_inc(m_cd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    in_code = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_single", out_single, 0);
    chk("rst_out_double", out_double, 0);
    chk("rst_cnt_single", cnt_single, 0);
    chk("rst_cnt_double", cnt_double, 0);
    rst = 1'b0;
    sb.delete();
    m_vld = 1'b0;
    m_cs = '0;
    m_cd = '0;
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic s, input logic dbl);
    exp_t e;
    e.d = d;
    e.s = s;
    e.dbl = dbl;
    return e;
  endfunction

  logic acc;
  exp_t e;
  logic [CW-1:0] words[4];
  exp_t wexp[4];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    in_code = '0;
    m_vld = 1'b0;
    m_cs = '0;
    m_cd = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed words from the test plan
    cycle(1'b1, 16'h000F, mk(11'h001, 1'b0, 1'b0), 1'b1, 1'b0, acc);
    chk("accept_clean", acc, 1);
    cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b0, acc);
    chk("clean_no_count", cnt_single, 0);
`ifdef SECDED_CORRECT_EN
    e = mk(11'h000, 1'b1, 1'b0);
`else
    e = mk(11'h002, 1'b1, 1'b0);
`endif
    cycle(1'b1, 16'h0020, e, 1'b1, 1'b0, acc);
    cycle(1'b1, 16'h000E, mk(11'h001, 1'b1, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b1, 16'h0003, mk(11'h000, 1'b0, 1'b1), 1'b1, 1'b0, acc);
    cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b0, acc);
    chk("cnt_single_two", cnt_single, 2);
    chk("cnt_double_one", cnt_double, 1);

    // Backpressure: four words, out_ready low for three cycles mid-stream
    for (int i = 0; i < 4; i++) begin
      words[i] = encode(DW'(11'h100 + 11'(i * 37)));
      wexp[i] = mk(DW'(11'h100 + 11'(i * 37)), 1'b0, 1'b0);
    end
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 14; c++) begin
        cycle(idx < 4, (idx < 4) ? words[idx] : '0, (idx < 4) ? wexp[idx] : mk('0, 0, 0),
              !(c >= 2 && c <= 4), 1'b0, acc);
        if (acc) idx++;
      end
      chk("bp_all_sent", idx, 4);
      chk("bp_drained", sb.size(), 0);
    end

    // Saturation and clear
    cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b1, acc);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, encode(DW'(i)) ^ 16'h0001, mk(DW'(i), 1'b1, 1'b0), 1'b1, 1'b0, acc);
    cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b0, acc);
    chk("cnt_single_sat", cnt_single, 3);
    cycle(1'b1, 16'h0001, mk(11'h000, 1'b1, 1'b0), 1'b1, 1'b1, acc);
    chk("cnt_clr_wins", cnt_single, 0);
    cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b0, acc);

    // Reset while a word is held
    cycle(1'b1, 16'h0003, mk(11'h000, 1'b0, 1'b1), 1'b0, 1'b0, acc);
    cycle(1'b0, '0, mk('0, 0, 0), 1'b0, 1'b0, acc);
    do_reset();
    cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b0, acc);

    // Random traffic: encoded data with 0, 1 or 2 flipped bits
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] d;
      logic [CW-1:0] c, cf;
      int nf, p1, p2;
      d = DW'($urandom);
      c = encode(d);
      cf = c;
      nf = $urandom_range(2, 0);
      p1 = $urandom_range(CW - 1, 0);
      p2 = (p1 + $urandom_range(CW - 1, 1)) % CW;
      if (nf >= 1) cf[p1] = ~cf[p1];
      if (nf == 2) cf[p2] = ~cf[p2];
      if (nf == 0) e = mk(d, 1'b0, 1'b0);
      else if (nf == 2) e = mk('0, 1'b0, 1'b1);
`ifdef SECDED_CORRECT_EN
      else e = mk(d, 1'b1, 1'b0);
`else
      else e = mk(unpack_data(cf), 1'b1, 1'b0);
`endif
      cycle($urandom_range(3, 0) != 0, cf, e, $urandom_range(3, 0) != 0,
            $urandom_range(15, 0) == 0, acc);
    end
    for (int n = 0; n < 4; n++)
      cycle(1'b0, '0, mk('0, 0, 0), 1'b1, 1'b0, acc);
    chk("final_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
